// File: rtl/conv_mac_unit.sv
// conv_mac_unit
// Convolution multiply-accumulate for one D x S x S window in signed
// fixed point (FRAC_BITS fractional bits). A window is registered on
// acceptance, LANES products are summed per cycle, and the accumulated
// result is shifted, biased and saturated into res.
//
// Optional feature (compile-time macro): CONV_MAC_UNIT_RELU_EN
//   defined   -> res = max(0, saturated result)
//   undefined -> res = saturated signed result
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-low reset
//   in_valid   in   img/fit/bias valid
//   in_ready   out  block can accept a window (IDLE)
//   img        in   N*DATA_WIDTH image window, element k at [k*DW +: DW]
//   fit        in   N*DATA_WIDTH filter weights, same packing
//   bias       in   DATA_WIDTH bias in output format
//   out_valid  out  res valid (DONE)
//   out_ready  in   consumer accepts res
//   res        out  DATA_WIDTH saturated result
//
// state | meaning
// IDLE  | waiting for a window, in_ready=1
// MAC   | summing one group of LANES products per cycle
// DONE  | res held with out_valid=1 until out_ready

module conv_mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int D          = 6,
    parameter int S          = 5,
    parameter int LANES      = 5,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [D*S*S*DATA_WIDTH-1:0] img,
    input  logic [D*S*S*DATA_WIDTH-1:0] fit,
    input  logic [DATA_WIDTH-1:0]       bias,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       res
);

    localparam int N  = D * S * S;
    localparam int G  = N / LANES;
    localparam int CW = (G > 1) ? $clog2(G) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] LAST_GROUP = CW'(G - 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state_q, state_d;

    logic [N*DATA_WIDTH-1:0]      img_q, fit_q;
    logic [DATA_WIDTH-1:0]        bias_q;
    logic signed [ACC_WIDTH-1:0]  acc, psum_q, lane_sum;
    logic                         psum_vld;
    logic                         drain;
    logic [CW-1:0]                cnt;

    logic [PW-1:0]                a_ext, b_ext, prod;
    logic signed [ACC_WIDTH-1:0]  acc_sum, shifted;
    logic signed [ACC_WIDTH:0]    total;
    logic                         fits;
    logic [DATA_WIDTH-1:0]        sat, res_next;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = MAC;
            end
            MAC: begin
                if (drain) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- lane products for group cnt ----------------
    always_comb begin
        lane_sum = '0;
        a_ext    = '0;
        b_ext    = '0;
        prod     = '0;
        for (int l = 0; l < LANES; l++) begin
            int idx;
            idx   = int'(cnt) * LANES + l;
            a_ext = {{DATA_WIDTH{img_q[idx*DATA_WIDTH + DATA_WIDTH - 1]}},
                     img_q[idx*DATA_WIDTH +: DATA_WIDTH]};
            b_ext = {{DATA_WIDTH{fit_q[idx*DATA_WIDTH + DATA_WIDTH - 1]}},
                     fit_q[idx*DATA_WIDTH +: DATA_WIDTH]};
            prod  = a_ext * b_ext;
            lane_sum = lane_sum + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
        end
    end

    // ---------------- output formatting ----------------
    // The last group's sum is still in psum_q when the result is formed.
    always_comb begin
        acc_sum = acc + (psum_vld ? psum_q : '0);
        shifted = acc_sum >>> FRAC_BITS;
        total   = {shifted[ACC_WIDTH-1], shifted}
                + {{(ACC_WIDTH+1-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
        fits    = (total[ACC_WIDTH:DATA_WIDTH-1] ==
                   {(ACC_WIDTH-DATA_WIDTH+2){total[ACC_WIDTH]}});
        if (fits)                sat = total[DATA_WIDTH-1:0];
        else if (total[ACC_WIDTH]) sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else                     sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`ifdef CONV_MAC_UNIT_RELU_EN
        res_next = sat[DATA_WIDTH-1] ? '0 : sat;
`else
        res_next = sat;
`endif
    end

    // ---------------- window capture (no reset needed) ----------------
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            img_q  <= img;
            fit_q  <= fit;
            bias_q <= bias;
        end
    end

    // ---------------- accumulate / result ----------------
    // Group sums are registered one cycle before entering the accumulator,
    // which places the DONE entry at N/LANES+1 edges after acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc      <= '0;
            psum_q   <= '0;
            psum_vld <= 1'b0;
            drain    <= 1'b0;
            cnt      <= '0;
            res      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= '0;
                        psum_vld <= 1'b0;
                        drain    <= 1'b0;
                        cnt      <= '0;
                    end
                end
                MAC: begin
                    if (psum_vld) acc <= acc + psum_q;
                    if (!drain) begin
                        psum_q   <= lane_sum;
                        psum_vld <= 1'b1;
                        if (cnt == LAST_GROUP) drain <= 1'b1;
                        else                   cnt   <= cnt + CW'(1);
                    end else begin
                        res <= res_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_unit.sv
module tb_conv_mac_unit;

    localparam int DW    = 16;
    localparam int FB    = 8;
    localparam int D     = 6;
    localparam int S     = 5;
    localparam int LANES = 5;
    localparam int AW    = 40;
    localparam int N     = D * S * S;
    localparam int LAT   = N / LANES + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b1;
    logic [N*DW-1:0] img = '0;
    logic [N*DW-1:0] fit = '0;
    logic [DW-1:0]   bias = '0;
    logic            in_ready, out_valid;
    logic [DW-1:0]   res;

    conv_mac_unit #(
        .DATA_WIDTH(DW), .FRAC_BITS(FB), .D(D), .S(S), .LANES(LANES), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .img(img), .fit(fit), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .res(res)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: full dot product in plain integer arithmetic.
    function automatic logic [DW-1:0] model(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                                            input logic [DW-1:0] bi);
        longint sum, t;
        logic signed [DW-1:0] ea, eb, sb;
        sum = 0;
        for (int k = 0; k < N; k++) begin
            ea = a[k*DW +: DW];
            eb = b[k*DW +: DW];
            sum += longint'(ea) * longint'(eb);
        end
        sb = bi;
        t = (sum >>> FB) + longint'(sb);
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
`ifdef CONV_MAC_UNIT_RELU_EN
        if (t < 0) t = 0;
`endif
        return t[DW-1:0];
    endfunction

    function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] v);
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = v;
        return r;
    endfunction

    // ---------------- cycle-by-cycle compare against the model ----------------
    bit            mon_en = 0;
    bit            busy = 0;
    int            acc_edge = 0;
    int            hs_edge = 0;
    logic [DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (mon_en) begin
            check_bit("in_ready", in_ready, !busy);
            check_bit("out_valid", out_valid, busy && (cyc - acc_edge >= LAT));
            if (out_valid && exp_q.size() > 0) check_val("res", res, exp_q[0]);
            if (!rst) begin
                busy = 0;
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    busy = 0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    hs_edge = cyc + 1;
                end
                if (in_valid && in_ready) begin
                    busy = 1;
                    acc_edge = cyc + 1;
                    exp_q.push_back(model(img, fit, bias));
                end
            end
        end
    end

    // ---------------- drivers (all changes at posedge + 1) ----------------
    task automatic scramble();
        for (int k = 0; k < N; k++) begin
            img[k*DW +: DW] = 16'($urandom);
            fit[k*DW +: DW] = 16'($urandom);
        end
        bias = 16'($urandom);
    endtask

    task automatic send(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, input logic [DW-1:0] bi);
        bit ok;
        ok = 0;
        img = a; fit = b; bias = bi; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        check_bit("accept_timeout", ok, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_res(input string name, input logic [DW-1:0] exp, output int seen_cyc);
        bit ok;
        ok = 0;
        seen_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check_val(name, res, exp);
                seen_cyc = cyc;
                ok = 1;
                break;
            end
        end
        check_bit({name, "_timeout"}, ok, 1'b1);
        @(posedge clk); #1;
    endtask

    logic [N*DW-1:0] pa, pb;
    int              seen, a0;
    bit              got;

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_val("rst_res", res, 16'h0000);
        rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1;

        // 150 * 1.0 * 0.5 = 75.0, latency 31 edges
        send(fill(16'h0100), fill(16'h0080), 16'h0000);
        a0 = acc_edge;
        wait_res("r_75", 16'h4B00, seen);
        check_int("latency", seen - a0, 31);

        // positive saturation
        send(fill(16'h0400), fill(16'h0400), 16'h0000);
        wait_res("r_possat", 16'h7FFF, seen);

        // negative saturation / relu clamp
        send(fill(16'hFF00), fill(16'h4000), 16'h0000);
`ifdef CONV_MAC_UNIT_RELU_EN
        wait_res("r_negsat", 16'h0000, seen);
`else
        wait_res("r_negsat", 16'h8000, seen);
`endif

        // -75 + 1 = -74.0
        send(fill(16'h0100), fill(16'hFF80), 16'h0100);
`ifdef CONV_MAC_UNIT_RELU_EN
        wait_res("r_m74", 16'h0000, seen);
`else
        wait_res("r_m74", 16'hB600, seen);
`endif

        // floor of -150/256 is -1 LSB
        send(fill(16'h0001), fill(16'hFFFF), 16'h0000);
`ifdef CONV_MAC_UNIT_RELU_EN
        wait_res("r_floor", 16'h0000, seen);
`else
        wait_res("r_floor", 16'hFFFF, seen);
`endif

        // per-element distinct values exercise lane/group indexing
        for (int k = 0; k < N; k++) begin
            pa[k*DW +: DW] = 16'(k * 13 - 900);
            pb[k*DW +: DW] = 16'((k % 7) * 37 - 100);
        end
        send(pa, pb, 16'h0042);
        wait_res("r_pattern", model(pa, pb, 16'h0042), seen);

        // back-pressure hold with ignored in_valid pulses
        out_ready = 1'b0;
        send(fill(16'h0000), fill(16'h1234), 16'h0123);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin got = 1; break; end
        end
        check_bit("hold_timeout", got, 1'b1);
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            in_valid = (j % 2 == 0);
            scramble();
            @(negedge clk);
            check_val("hold_res", res, 16'h0123);
            check_bit("hold_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // reset in the middle of MAC, then a clean window
        send(fill(16'h0200), fill(16'h0300), 16'h0010);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send(fill(16'h0100), fill(16'h0080), 16'h0000);
        wait_res("r_after_rst", 16'h4B00, seen);

        // back-to-back windows
        send(fill(16'h0100), fill(16'h0080), 16'h0000);
        send(fill(16'h0200), fill(16'h0040), 16'h0100);
        check_int("b2b_gap", acc_edge - hs_edge, 1);
        wait_res("r_b2b", 16'h4C00, seen);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
